// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: instruction layout, opcodes and FSM encoding.
package alu_sequencer_pkg;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned ACC_W   = 8;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned FUNC_W  = 3;

  // Instruction layout: {halt, func[2:0], data[3:0]}
  localparam int unsigned HALT_BIT = 7;
  localparam int unsigned FUNC_MSB = 6;
  localparam int unsigned FUNC_LSB = 4;
  localparam int unsigned DATA_MSB = 3;
  localparam int unsigned DATA_LSB = 0;

  localparam logic [FUNC_W-1:0] OP_INC   = 3'd0;
  localparam logic [FUNC_W-1:0] OP_ADD   = 3'd1;
  localparam logic [FUNC_W-1:0] OP_ADDV  = 3'd2;
  localparam logic [FUNC_W-1:0] OP_LOGIC = 3'd3;
  localparam logic [FUNC_W-1:0] OP_ROR   = 3'd4;
  localparam logic [FUNC_W-1:0] OP_SHL   = 3'd5;
  localparam logic [FUNC_W-1:0] OP_SHR   = 3'd6;
  localparam logic [FUNC_W-1:0] OP_MUL   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sequencer_alu_core.sv
// Combinational ALU: 4-bit operands A (instruction data) and B (acc low nibble), 8-bit result.
module alu_core
  import alu_sequencer_pkg::*;
(
  input  logic [FUNC_W-1:0] func,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  result_c
);

  always_comb begin
    result_c = '0;
    case (func)
      OP_INC:         result_c = ACC_W'(a) + ACC_W'(1);
      OP_ADD, OP_ADDV: result_c = ACC_W'(a) + ACC_W'(b);
      OP_LOGIC:       result_c = {a | b, a ^ b};
      OP_ROR:         result_c = {7'b0, |(a | b)};
      // Shift amounts of 8 or more flush the operand out entirely
      OP_SHL:         result_c = (a >= 4'd8) ? '0 : ACC_W'({4'b0, b} << a);
      OP_SHR:         result_c = (a >= 4'd8) ? '0 : ACC_W'({4'b0, b} >> a);
      OP_MUL:         result_c = ACC_W'(a) * ACC_W'(b);
      default:        result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction-store sequencer: loads a small program in IDLE, then runs it against an
// 8-bit accumulator in free-run or single-step mode.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [INSTR_W-1:0]         load_instr,
  input  logic                       start,
  input  logic                       step_mode,
  input  logic                       step,
  output logic [ACC_W-1:0]           acc,
  output logic [$clog2(DEPTH)-1:0]   pc,
  output logic                       busy,
  output logic                       done,
  output logic                       load_rej
);

  localparam int unsigned PC_W = $clog2(DEPTH);

  state_t               state, state_d;
  logic [INSTR_W-1:0]   store [DEPTH];
  logic                 start_q, step_q, mode_q, mode_d;
  logic [ACC_W-1:0]     acc_d, alu_result;
  logic [PC_W-1:0]      pc_d;
  logic                 busy_d, done_d, rej_d, store_we;
  logic                 start_edge, step_edge, exec;
  logic [INSTR_W-1:0]   instr;

  assign start_edge = start & ~start_q;
  assign step_edge  = step & ~step_q;
  assign instr      = store[pc];
  assign exec       = ~mode_q | step_edge;

  alu_core u_alu (
    .func     (instr[FUNC_MSB:FUNC_LSB]),
    .a        (instr[DATA_MSB:DATA_LSB]),
    .b        (acc[DATA_W-1:0]),
    .result_c (alu_result)
  );

  // Next-state and datapath updates
  always_comb begin
    state_d  = state;
    acc_d    = acc;
    pc_d     = pc;
    mode_d   = mode_q;
    store_we = 1'b0;
    case (state)
      IDLE: begin
        store_we = load_en;
        if (start_edge) begin
          acc_d   = '0;
          pc_d    = '0;
          mode_d  = step_mode;
          state_d = RUN;
        end
      end
      RUN: begin
        if (exec) begin
          acc_d = alu_result;
          if (instr[HALT_BIT] || (pc == PC_W'(DEPTH - 1))) state_d = DONE;
          else                                              pc_d    = pc + PC_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    rej_d  = load_en & (state != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      acc      <= '0;
      pc       <= '0;
      mode_q   <= 1'b0;
      start_q  <= 1'b0;
      step_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      load_rej <= 1'b0;
    end else begin
      state    <= state_d;
      acc      <= acc_d;
      pc       <= pc_d;
      mode_q   <= mode_d;
      start_q  <= start;
      step_q   <= step;
      busy     <= busy_d;
      done     <= done_d;
      load_rej <= rej_d;
    end
  end

  // Instruction store; writes accepted only in IDLE
  always_ff @(posedge clock) begin
    if (!reset_n)      store            <= '{default: '0};
    else if (store_we) store[load_addr] <= load_instr;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Programmable controller that sequences the register-ALU datapath. It holds an 8-entry instruction store loaded from switches and, on a start edge, issues one ALU operation per cycle against an 8-bit accumulator until a halt bit or the last entry. It supports free-run and single-step modes, and sits between the board inputs (SW/KEY) and the LEDR/HEX display path.

## Interface
- Parameters:
- DEPTH, 8, number of instruction entries (power of two; PC width = log2(DEPTH)).
- Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- load_en  in  1  write load_instr into store at load_addr this cycle.
- load_addr  in  3  store write address.
- load_instr  in  8  {halt, func[2:0], data[3:0]}.
- start  in  1  level; a rising edge, detected internally, launches a run.
- step_mode  in  1  1 = advance only on step edges; sampled at the start edge.
- step  in  1  level; a rising edge, detected internally, executes one instruction in step mode.
- acc  out  8  accumulator (ALU result register).
- pc  out  3  index of the next instruction to execute.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a run completes.
- load_rej  out  1  one-cycle pulse when load_en is asserted outside IDLE.

## Operation
- Reset state: state IDLE, acc 0, pc 0, busy 0, done 0, load_rej 0, all store entries 8'h00, start/step edge registers 0.
- FSM states:
- IDLE: load_en writes store[load_addr]. A start edge clears acc and pc, latches step_mode, and moves to RUN.
- RUN: executes store[pc] when enabled. Enable is every cycle in free-run, or the step-edge cycle in step mode. On an executed cycle, acc <= alu(func, A=data, B=acc[3:0]). If halt=1 or pc==DEPTH-1, go to DONE; otherwise pc <= pc+1. In step mode with no step edge, acc and pc hold.
- DONE: done=1 for one cycle, then go to IDLE. acc and pc hold and stay visible in IDLE.
- Store writes outside IDLE are dropped; load_rej pulses in the following cycle.
- start edges outside IDLE are ignored. start held high through DONE does not retrigger; a new low-to-high edge is required.
- ALU functions (A 4 bits, B 4 bits, result 8 bits):
- 000: {3'b0, carry, A+1}.
- 001 and 010: {3'b0, carry, A+B}.
- 011: {A|B, A^B}.
- 100: {7'b0, |(A|B)}.
- 101: {4'b0,B} << A.
- 110: {4'b0,B} >> A.
- 111: A*B (unsigned 8 bits).
- Shift amounts of 8 or more yield 0.
- The PC never wraps. Reaching the last entry always terminates the run.

## Timing
- Start edge sampled at rising edge n: cycle n+1 is the first RUN cycle (busy=1, pc=0, acc=0).
- Free-run program of k instructions: last execute at edge n+k, done=1 and busy=0 in cycle n+k+1, IDLE in cycle n+k+2.
- Step mode: the step edge is detected on the cycle step is first seen high; that instruction's result appears in acc at the next edge.
- Load: a write at edge m is readable by a run started at edge m+1 or later.
- Reset wins over all events. reset_n=0 during RUN returns to IDLE at the next edge, with acc=0 and no done pulse.
- load_en together with a start edge in IDLE: the write completes, and the run begins with the updated store.

## Structure
- Shared package holds:
- Opcode localparams OP_INC, OP_ADD, OP_ADDV, OP_LOGIC, OP_ROR, OP_SHL, OP_SHR, OP_MUL.
- Instruction field positions (HALT_BIT=7, FUNC=6:4, DATA=3:0).
- FSM state encoding IDLE/RUN/DONE.
- One sub-module, alu_core: purely combinational (func, A, B) -> result[7:0]. The sequencer owns the store, the edge detectors, the FSM and the acc register.

## Test plan
- Load store[0]=8'h03 and store[1]=8'hF2, then free-run start: acc=0x04 after the first RUN cycle, then 0x08. done pulses 3 cycles after the start edge, pc=1.
- Fill all 8 entries with 8'h11 (A+B, data 1, no halt): acc counts 1..8 and run stops at pc=7. done pulses 9 cycles after the start edge.
- Step mode with 2 instructions (8'h03, 8'hD1): no step edges for 10 cycles leaves acc=0 and busy=1. The first step edge gives acc=0x04. The second gives acc=0x08 (0x4<<1) and then done.
- Assert load_en to address 0 during RUN: load_rej pulses, and a rerun shows the old store[0] result.
- Assert reset_n=0 on the third RUN cycle of the 8-entry program: next cycle IDLE, acc=0, pc=0, busy=0, no done pulse.
- Hold start high through DONE: no second run. Drop start and raise it again: a new run starts with acc cleared.
